// File: rtl/sub_seq_nb.sv
// Multi-cycle subtractor: diff = a - b, one 4-bit slice per clock with the carry registered between slices.
// Optional signed-overflow flag (port ovf) is built only when SUB_OVF_EN is defined.
module sub_seq_nb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [3:0]      a_sl    [NSLICE];
  logic [3:0]      b_sl    [NSLICE];
  logic [3:0]      diff_sl [NSLICE];
  logic [4:0]      slice_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_sl[gi] = a_r[4*gi +: 4];
      assign b_sl[gi] = b_r[4*gi +: 4];
      assign diff[4*gi +: 4] = diff_sl[gi];
    end
  endgenerate

  // Two's-complement slice: a + ~b + carry, carry seeded with 1 on slice 0.
  always_comb begin
    slice_sum = {1'b0, a_sl[idx]} + {1'b0, ~b_sl[idx]} + {4'b0000, carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      borrow_out <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      idx        <= '0;
      carry      <= 1'b1;
      for (int i = 0; i < NSLICE; i++) diff_sl[i] <= 4'h0;
`ifdef SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            idx   <= '0;
            carry <= 1'b1;
            busy  <= 1'b1;
            for (int i = 0; i < NSLICE; i++) diff_sl[i] <= 4'h0;
`ifdef SUB_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          diff_sl[idx] <= slice_sum[3:0];
          carry        <= slice_sum[4];
          idx          <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            borrow_out <= ~slice_sum[4];
`ifdef SUB_OVF_EN
            ovf        <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (slice_sum[3] != a_r[WIDTH-1]);
`endif
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_seq_nb.sv
// Self-checking bench for sub_seq_nb (WIDTH=16): directed cases plus random operands against an arithmetic model.
module tb_sub_seq_nb;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow_out;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif

  int vectors;
  int miscompares;

  sub_seq_nb #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [15:0] model_diff(input logic [15:0] x, input logic [15:0] y);
    int d;
    d = int'(x) - int'(y);
    if (d < 0) d += 65536;
    return d[15:0];
  endfunction

  function automatic logic model_borrow(input logic [15:0] x, input logic [15:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic model_ovf(input logic [15:0] x, input logic [15:0] y);
    int sx, sy, d;
    sx = int'($signed(x));
    sy = int'($signed(y));
    d  = sx - sy;
    return (d > 32767) || (d < -32768);
  endfunction

  // One full operation; poke=1 pulses start (with other operands) while RUN is in progress.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input bit poke);
    logic [15:0] ed;
    logic        eb;
    ed = model_diff(ta, tb);
    eb = model_borrow(ta, tb);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_diff_clr", 32'(diff), 32'd0);
    a = 16'($urandom);
    b = 16'($urandom);
    for (int k = 1; k <= 4; k++) begin
      if (poke && k == 1) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < 4) begin
        check("run_done_low", 32'(done), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("diff", 32'(diff), 32'(ed));
        check("borrow_out", 32'(borrow_out), 32'(eb));
`ifdef SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(model_ovf(ta, tb)));
`endif
      end
    end
    @(posedge clk); #1;
    check("done_single", 32'(done), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("diff_held", 32'(diff), 32'(ed));
    check("borrow_held", 32'(borrow_out), 32'(eb));
    $display("op a=%h b=%h diff=%h borrow_out=%b done_seen=1", ta, tb, diff, borrow_out);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    do_op(16'h1234, 16'h0234, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0);
    do_op(16'hA5A5, 16'hA5A5, 1'b0);
    do_op(16'h0005, 16'h0003, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b0);
    do_op(16'h0003, 16'h0001, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    $display("op a=4321 b=1111 aborted by reset");
    do_op(16'h0010, 16'h0001, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (n % 8 == 0) ? ra : 16'($urandom);
      do_op(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
